d_mem_axi_slave: RTL



---
 rtl/d_mem_pkg.sv | 36 +++
 rtl/d_mem_lane_write.sv | 20 ++
 rtl/d_mem_axi_slave.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/d_mem_pkg.sv
// Shared types and helpers for the d_mem AXI-lite data memory slave.
// Holds AXI response codes, write/read FSM encodings and the lane-mask helper.
package d_mem_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_COMMIT,
      W_RESP
   } w_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_DATA
   } r_state_t;

   // Byte wins over halfword when both size bits are set.
   function automatic logic [3:0] lane_mask(
      input logic       is_byte,
      input logic       is_hword,
      input logic [1:0] lo
   );
      logic [3:0] m;
      if (is_byte)
         m = 4'b0001 << lo;
      else if (is_hword)
         m = lo[1] ? 4'b1100 : 4'b0011;
      else
         m = 4'b1111;
      return m;
   endfunction

endpackage

// File: rtl/d_mem_lane_write.sv
// Byte-lane merge of lane-aligned write data into a stored word.
// Ports: old_word (stored), wdata (lane aligned), mask (per byte), new_word.
module d_mem_lane_write #(
   parameter int DATA = 32
) (
   input  logic [DATA-1:0]   old_word,
   input  logic [DATA-1:0]   wdata,
   input  logic [DATA/8-1:0] mask,
   output logic [DATA-1:0]   new_word
);

   always_comb begin
      new_word = old_word;
      for (int i = 0; i < DATA/8; i++) begin
         if (mask[i])
            new_word[8*i +: 8] = wdata[8*i +: 8];
      end
   end

endmodule

// File: rtl/d_mem_axi_slave.sv
// AXI-lite data memory slave: sized single-word writes, N_WORD-word line reads
// returned RD_LAT cycles after AR. Ports: CLK, rst (sync, active high), AXI
// AW/W/B/AR/R channels, WR_Byte/WR_HWORD size qualifiers.
// Optional macro D_MEM_RESP_ERR_EN: out-of-range accesses answer SLVERR.
module d_mem_axi_slave
   import d_mem_pkg::*;
#(
   parameter int N_WORD    = 4,
   parameter int DATA      = 32,
   parameter int WIDTH_ADD = 32,
   parameter int DEPTH     = 1024,
   parameter int RD_LAT    = 2
) (
   input  logic                   CLK,
   input  logic                   rst,
   input  logic                   AXI_AWVALID,
   input  logic [WIDTH_ADD-1:0]   AXI_AWADDR,
   input  logic [2:0]             AXI_AWPROT,
   input  logic [3:0]             AXI_AWCACHE,
   output logic                   AXI_AWREADY,
   input  logic                   AXI_WVALID,
   input  logic [DATA-1:0]        AXI_WDATA,
   input  logic [3:0]             AXI_WSTRB,
   output logic                   AXI_WREADY,
   input  logic                   WR_Byte,
   input  logic                   WR_HWORD,
   output logic                   AXI_BVALID,
   output logic [1:0]             AXI_BRESP,
   input  logic                   AXI_BREADY,
   input  logic                   AXI_ARVALID,
   input  logic [WIDTH_ADD-1:0]   AXI_ARADDR,
   input  logic [2:0]             AXI_ARPROT,
   input  logic [3:0]             AXI_ARCACHE,
   output logic                   AXI_ARREADY,
   output logic                   AXI_RVALID,
   output logic [DATA*N_WORD-1:0] AXI_RDATA,
   output logic [1:0]             AXI_RRESP,
   input  logic                   AXI_RREADY
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int NB = DATA / 8;

   w_state_t w_state, w_nxt;
   r_state_t r_state, r_nxt;

   logic              alive;
   logic              aw_rdy, w_rdy, ar_rdy;
   logic              aw_hs, w_hs, ar_hs;
   logic              aw_held, w_held;
   logic [AW-1:0]     aw_idx;
   logic [1:0]        aw_lo;
   logic              aw_err, aw_err_in;
   logic [DATA-1:0]   wdata_q, wdata_al;
   logic [3:0]        wstrb_q, wmask;
   logic              wr_byte_q, wr_hword_q;
   logic [1:0]        bresp_q;
   logic [DATA-1:0]   old_word, new_word;
   logic              wr_we;

   logic [DATA-1:0]   mem [DEPTH];

   logic [AW-1:0]     ar_base, base_q, sel_base, rd_idx;
   logic              ar_err, err_q, sel_err;
   logic              rd_load;
   logic [CW-1:0]     cnt;
   logic [DATA*N_WORD-1:0] line, rdata_q;
   logic [1:0]        rresp_q;

   logic              unused;
   assign unused = ^{AXI_AWPROT, AXI_AWCACHE, AXI_ARPROT,
                     AXI_ARCACHE, AXI_AWADDR, AXI_ARADDR};

`ifdef D_MEM_RESP_ERR_EN
   // Lines are aligned and DEPTH is a power of two, so a line runs past
   // the end only when its base index is itself out of range.
   assign aw_err_in = |AXI_AWADDR[WIDTH_ADD-1:2+AW];
   assign ar_err    = |AXI_ARADDR[WIDTH_ADD-1:2+AW];
`else
   assign aw_err_in = 1'b0;
   assign ar_err    = 1'b0;
`endif

   // ---------------- write channel ----------------
   always_comb begin
      w_nxt  = w_state;
      aw_rdy = 1'b0;
      w_rdy  = 1'b0;
      unique case (w_state)
         W_IDLE: begin
            aw_rdy = alive && !aw_held;
            w_rdy  = alive && !w_held;
            if ((aw_held || (AXI_AWVALID && aw_rdy)) &&
                (w_held  || (AXI_WVALID  && w_rdy)))
               w_nxt = W_COMMIT;
         end
         W_COMMIT: w_nxt = W_RESP;
         W_RESP:   if (AXI_BREADY) w_nxt = W_IDLE;
         default:  w_nxt = W_IDLE;
      endcase
   end

   assign aw_hs = AXI_AWVALID && aw_rdy;
   assign w_hs  = AXI_WVALID && w_rdy;

   always_ff @(posedge CLK) begin
      if (rst) w_state <= W_IDLE;
      else     w_state <= w_nxt;
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         alive      <= 1'b0;
         aw_held    <= 1'b0;
         w_held     <= 1'b0;
         aw_idx     <= '0;
         aw_lo      <= '0;
         aw_err     <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         wr_byte_q  <= 1'b0;
         wr_hword_q <= 1'b0;
         bresp_q    <= RESP_OKAY;
      end else begin
         alive <= 1'b1;
         if (aw_hs) begin
            aw_held <= 1'b1;
            aw_idx  <= AXI_AWADDR[2 +: AW];
            aw_lo   <= AXI_AWADDR[1:0];
            aw_err  <= aw_err_in;
         end
         if (w_hs) begin
            w_held     <= 1'b1;
            wdata_q    <= AXI_WDATA;
            wstrb_q    <= AXI_WSTRB;
            wr_byte_q  <= WR_Byte;
            wr_hword_q <= WR_HWORD;
         end
         if (w_state == W_COMMIT) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= aw_err ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   // Right-justified data is replicated so every candidate lane sees it.
   always_comb begin
      if (wr_byte_q)
         wdata_al = {NB{wdata_q[7:0]}};
      else if (wr_hword_q)
         wdata_al = {(NB/2){wdata_q[15:0]}};
      else
         wdata_al = wdata_q;
   end

   assign wmask    = lane_mask(wr_byte_q, wr_hword_q, aw_lo) & wstrb_q;
   assign old_word = mem[aw_idx];
   assign wr_we    = (w_state == W_COMMIT) && !rst && !aw_err &&
                     (wmask != '0);

   d_mem_lane_write #(.DATA(DATA)) u_lane (
      .old_word (old_word),
      .wdata    (wdata_al),
      .mask     (wmask),
      .new_word (new_word)
   );

   always_ff @(posedge CLK) begin
      if (wr_we) mem[aw_idx] <= new_word;
   end

   // ---------------- read channel ----------------
   always_comb begin
      r_nxt  = r_state;
      ar_rdy = 1'b0;
      unique case (r_state)
         R_IDLE: begin
            ar_rdy = alive;
            if (AXI_ARVALID && alive) begin
               if (RD_LAT == 1) r_nxt = R_DATA;
               else             r_nxt = R_WAIT;
            end
         end
         R_WAIT:  if (cnt == '0) r_nxt = R_DATA;
         R_DATA:  if (AXI_RREADY) r_nxt = R_IDLE;
         default: r_nxt = R_IDLE;
      endcase
   end

   assign ar_hs    = AXI_ARVALID && ar_rdy;
   assign ar_base  = AXI_ARADDR[2 +: AW] & ~(AW'(N_WORD - 1));
   assign rd_load  = (r_nxt == R_DATA) && (r_state != R_DATA);
   assign sel_base = (r_state == R_IDLE) ? ar_base : base_q;
   assign sel_err  = (r_state == R_IDLE) ? ar_err : err_q;

   // A commit on the same edge as the line capture is forwarded so the
   // read observes the freshly written word.
   always_comb begin
      line   = '0;
      rd_idx = '0;
      for (int k = 0; k < N_WORD; k++) begin
         rd_idx = sel_base + AW'(k);
         line[k*DATA +: DATA] = (wr_we && (rd_idx == aw_idx)) ?
                                new_word : mem[rd_idx];
      end
      if (sel_err) line = '0;
   end

   always_ff @(posedge CLK) begin
      if (rst) r_state <= R_IDLE;
      else     r_state <= r_nxt;
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         cnt     <= '0;
         base_q  <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else begin
         if (ar_hs) begin
            base_q <= ar_base;
            err_q  <= ar_err;
            cnt    <= CW'((RD_LAT > 1) ? (RD_LAT - 2) : 0);
         end else if ((r_state == R_WAIT) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
         end
         if (rd_load) begin
            rdata_q <= line;
            rresp_q <= sel_err ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   assign AXI_AWREADY = aw_rdy;
   assign AXI_WREADY  = w_rdy;
   assign AXI_BVALID  = (w_state == W_RESP);
   assign AXI_BRESP   = bresp_q;
   assign AXI_ARREADY = ar_rdy;
   assign AXI_RVALID  = (r_state == R_DATA);
   assign AXI_RDATA   = rdata_q;
   assign AXI_RRESP   = rresp_q;

endmodule
